nodf_module_status_tracker: RTL and testbench



---
 rtl/nodf_module_status_tracker.sv | 147 ++++++++++++++
 tb/tb_nodf_module_status_tracker.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/nodf_module_status_tracker.sv
// Passive status tracker for the ap_ctrl handshake of one non-dataflow HLS module.
// Samples start/ready/done/continue, tracks module state and per-transaction
// latency, start-to-start interval and stall statistics until finish is seen.
module nodf_module_status_tracker #(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned TXN_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ap_start,
  input  logic             ap_ready,
  input  logic             ap_done,
  input  logic             ap_continue,
  input  logic             finish,
  output logic [1:0]       state,
  output logic [TXN_W-1:0] txn_count,
  output logic             rec_valid,
  output logic [CNT_W-1:0] rec_latency,
  output logic [CNT_W-1:0] rec_interval,
  output logic [CNT_W-1:0] lat_min,
  output logic [CNT_W-1:0] lat_max,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             finished,
  output logic             pending_at_finish,
  output logic             protocol_err
);

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StActive   = 2'd1,
    StStall    = 2'd2,
    StFinished = 2'd3
  } state_e;

  state_e           r_state;
  logic [CNT_W-1:0] r_now;
  logic [CNT_W-1:0] r_start_t;
  logic             r_have_start;
  logic [CNT_W-1:0] r_cur_interval;
  logic [TXN_W-1:0] r_txn_count;
  logic             r_rec_valid;
  logic [CNT_W-1:0] r_rec_latency;
  logic [CNT_W-1:0] r_rec_interval;
  logic [CNT_W-1:0] r_lat_min;
  logic [CNT_W-1:0] r_lat_max;
  logic [CNT_W-1:0] r_stall_cycles;
  logic             r_finished;
  logic             r_pending;
  logic             r_protocol_err;

  logic             w_idle;
  logic             w_busy;
  logic             w_done_ev;
  logic             w_start_ev;
  logic             w_stall_cyc;
  logic             w_proto;
  logic [CNT_W-1:0] w_new_interval;
  logic [CNT_W-1:0] w_latency;
  logic [CNT_W-1:0] w_done_interval;

  // Event decode; start/done mutual dependence is resolved per state.
  always_comb begin
    w_idle          = (r_state == StIdle);
    w_busy          = (r_state == StActive) || (r_state == StStall);
    // From IDLE a done only counts when it arrives with its own start (zero latency).
    w_done_ev       = ap_done & ap_continue & ~finish & (w_busy | (w_idle & ap_start));
    // While busy a new start is only accepted together with the completing done.
    w_start_ev      = ap_start & ~finish & (w_idle | (w_busy & w_done_ev));
    w_stall_cyc     = ap_done & ~ap_continue & ~finish & (r_state != StFinished);
    w_proto         = w_idle & ~ap_start & (ap_done | ap_ready) & ~finish;
    w_new_interval  = r_have_start ? (r_now - r_start_t) : '0;
    w_latency       = w_idle ? '0 : (r_now - r_start_t);
    // Same-cycle start+done from IDLE completes the transaction being started now.
    w_done_interval = w_idle ? w_new_interval : r_cur_interval;
  end

  // State machine, counters, records and sticky flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= StIdle;
      r_now          <= '0;
      r_start_t      <= '0;
      r_have_start   <= 1'b0;
      r_cur_interval <= '0;
      r_txn_count    <= '0;
      r_rec_valid    <= 1'b0;
      r_rec_latency  <= '0;
      r_rec_interval <= '0;
      r_lat_min      <= '1;
      r_lat_max      <= '0;
      r_stall_cycles <= '0;
      r_finished     <= 1'b0;
      r_pending      <= 1'b0;
      r_protocol_err <= 1'b0;
    end else begin
      r_now       <= r_now + 1'b1;
      r_rec_valid <= w_done_ev;

      if (finish) begin
        r_state    <= StFinished;
        r_finished <= 1'b1;
        if (w_busy) r_pending <= 1'b1;
      end else begin
        unique case (r_state)
          StIdle: begin
            if (w_start_ev && !w_done_ev) r_state <= StActive;
          end
          StActive, StStall: begin
            if (w_done_ev)                  r_state <= w_start_ev ? StActive : StIdle;
            else if (ap_done && !ap_continue) r_state <= StStall;
          end
          default: r_state <= StFinished;
        endcase
      end

      if (w_start_ev) begin
        r_start_t      <= r_now;
        r_have_start   <= 1'b1;
        r_cur_interval <= w_new_interval;
      end

      if (w_done_ev) begin
        if (r_txn_count != '1) r_txn_count <= r_txn_count + 1'b1;
        r_rec_latency  <= w_latency;
        r_rec_interval <= w_done_interval;
        if (w_latency < r_lat_min) r_lat_min <= w_latency;
        if (w_latency > r_lat_max) r_lat_max <= w_latency;
      end

      if (w_stall_cyc && (r_stall_cycles != '1)) r_stall_cycles <= r_stall_cycles + 1'b1;
      if (w_proto) r_protocol_err <= 1'b1;
    end
  end

  assign state             = r_state;
  assign txn_count         = r_txn_count;
  assign rec_valid         = r_rec_valid;
  assign rec_latency       = r_rec_latency;
  assign rec_interval      = r_rec_interval;
  assign lat_min           = r_lat_min;
  assign lat_max           = r_lat_max;
  assign stall_cycles      = r_stall_cycles;
  assign finished          = r_finished;
  assign pending_at_finish = r_pending;
  assign protocol_err      = r_protocol_err;

endmodule

// File: tb/tb_nodf_module_status_tracker.sv
// Directed bench for nodf_module_status_tracker: single, back-to-back, stall,
// zero-latency, finish and protocol/reset scenarios with hand-computed results.
module tb_nodf_module_status_tracker;

  localparam int unsigned CNT_W = 32;
  localparam int unsigned TXN_W = 16;

  logic             clock;
  logic             reset;
  logic             ap_start;
  logic             ap_ready;
  logic             ap_done;
  logic             ap_continue;
  logic             finish;
  logic [1:0]       state;
  logic [TXN_W-1:0] txn_count;
  logic             rec_valid;
  logic [CNT_W-1:0] rec_latency;
  logic [CNT_W-1:0] rec_interval;
  logic [CNT_W-1:0] lat_min;
  logic [CNT_W-1:0] lat_max;
  logic [CNT_W-1:0] stall_cycles;
  logic             finished;
  logic             pending_at_finish;
  logic             protocol_err;

  int tests_run;
  int tests_failed;

  nodf_module_status_tracker #(
    .CNT_W(CNT_W),
    .TXN_W(TXN_W)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .ap_start         (ap_start),
    .ap_ready         (ap_ready),
    .ap_done          (ap_done),
    .ap_continue      (ap_continue),
    .finish           (finish),
    .state            (state),
    .txn_count        (txn_count),
    .rec_valid        (rec_valid),
    .rec_latency      (rec_latency),
    .rec_interval     (rec_interval),
    .lat_min          (lat_min),
    .lat_max          (lat_max),
    .stall_cycles     (stall_cycles),
    .finished         (finished),
    .pending_at_finish(pending_at_finish),
    .protocol_err     (protocol_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one cycle; inputs set afterwards apply to the next cycle.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    ap_start     = 1'b0;
    ap_ready     = 1'b0;
    ap_done      = 1'b0;
    ap_continue  = 1'b1;
    finish       = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_state", 64'(state), 64'd0);
    check("rst_txn", 64'(txn_count), 64'd0);
    check("rst_lat_min", 64'(lat_min), 64'hFFFF_FFFF);
    check("rst_lat_max", 64'(lat_max), 64'd0);
    check("rst_rec_valid", 64'(rec_valid), 64'd0);
    check("rst_flags", 64'({finished, pending_at_finish, protocol_err}), 64'd0);
    reset = 1'b0;

    // Single transaction: start at cycle 5, done at cycle 9
    repeat (5) tick();
    ap_start = 1'b1; tick();
    check("t1_active", 64'(state), 64'd1);
    ap_start = 1'b0; repeat (3) tick();
    ap_done = 1'b1; tick();
    check("t1_state", 64'(state), 64'd0);
    check("t1_txn", 64'(txn_count), 64'd1);
    check("t1_valid", 64'(rec_valid), 64'd1);
    check("t1_lat", 64'(rec_latency), 64'd4);
    check("t1_int", 64'(rec_interval), 64'd0);
    check("t1_min", 64'(lat_min), 64'd4);
    check("t1_max", 64'(lat_max), 64'd4);
    ap_done = 1'b0; tick();
    check("t1_valid_drop", 64'(rec_valid), 64'd0);

    // Back-to-back: starts at 2, 6, 10; dones at 6, 10, 14
    do_reset();
    repeat (2) tick();
    ap_start = 1'b1; tick();
    ap_start = 1'b0; repeat (3) tick();
    ap_start = 1'b1; ap_done = 1'b1; tick();
    check("b2b1_txn", 64'(txn_count), 64'd1);
    check("b2b1_lat", 64'(rec_latency), 64'd4);
    check("b2b1_int", 64'(rec_interval), 64'd0);
    check("b2b1_state", 64'(state), 64'd1);
    ap_start = 1'b0; ap_done = 1'b0; repeat (3) tick();
    ap_start = 1'b1; ap_done = 1'b1; tick();
    check("b2b2_txn", 64'(txn_count), 64'd2);
    check("b2b2_lat", 64'(rec_latency), 64'd4);
    check("b2b2_int", 64'(rec_interval), 64'd4);
    ap_start = 1'b0; ap_done = 1'b0; repeat (3) tick();
    ap_done = 1'b1; tick();
    check("b2b3_txn", 64'(txn_count), 64'd3);
    check("b2b3_lat", 64'(rec_latency), 64'd4);
    check("b2b3_int", 64'(rec_interval), 64'd4);
    check("b2b3_state", 64'(state), 64'd0);
    ap_done = 1'b0; tick();

    // Stall: done with continue low for 3 cycles
    ap_start = 1'b1; tick();
    ap_start = 1'b0; tick();
    ap_done = 1'b1; ap_continue = 1'b0; tick();
    check("st_state", 64'(state), 64'd2);
    check("st_valid", 64'(rec_valid), 64'd0);
    repeat (2) tick();
    check("st_cycles", 64'(stall_cycles), 64'd3);
    ap_continue = 1'b1; tick();
    check("st_done_state", 64'(state), 64'd0);
    check("st_txn", 64'(txn_count), 64'd4);
    check("st_lat", 64'(rec_latency), 64'd5);
    check("st_max", 64'(lat_max), 64'd5);
    check("st_min", 64'(lat_min), 64'd4);
    ap_done = 1'b0; tick();

    // Zero latency from IDLE
    ap_start = 1'b1; ap_done = 1'b1; tick();
    check("z_txn", 64'(txn_count), 64'd5);
    check("z_lat", 64'(rec_latency), 64'd0);
    check("z_state", 64'(state), 64'd0);
    check("z_min", 64'(lat_min), 64'd0);
    check("z_perr", 64'(protocol_err), 64'd0);
    ap_start = 1'b0; ap_done = 1'b0; tick();

    // Finish mid-transaction: start at 3, finish at 6
    do_reset();
    repeat (3) tick();
    ap_start = 1'b1; tick();
    ap_start = 1'b0; repeat (2) tick();
    finish = 1'b1; tick();
    check("f_state", 64'(state), 64'd3);
    check("f_finished", 64'(finished), 64'd1);
    check("f_pending", 64'(pending_at_finish), 64'd1);
    finish = 1'b0; ap_done = 1'b1; tick();
    check("f_txn", 64'(txn_count), 64'd0);
    check("f_valid", 64'(rec_valid), 64'd0);
    check("f_absorb", 64'(state), 64'd3);
    ap_done = 1'b0;

    // Finish and done in the same cycle: finish wins
    do_reset();
    ap_start = 1'b1; tick();
    ap_start = 1'b0; tick();
    ap_done = 1'b1; finish = 1'b1; tick();
    check("fd_txn", 64'(txn_count), 64'd0);
    check("fd_pending", 64'(pending_at_finish), 64'd1);
    check("fd_valid", 64'(rec_valid), 64'd0);
    ap_done = 1'b0; finish = 1'b0;

    // Reset overrides finish
    reset = 1'b1; finish = 1'b1; tick();
    check("rf_state", 64'(state), 64'd0);
    check("rf_finished", 64'(finished), 64'd0);
    reset = 1'b0; finish = 1'b0;

    // Protocol error: done while IDLE without start
    ap_done = 1'b1; tick();
    check("pe_done", 64'(protocol_err), 64'd1);
    ap_done = 1'b0;
    ap_start = 1'b1; tick();
    check("pe_active", 64'(state), 64'd1);
    ap_start = 1'b0;
    // Reset mid-transaction
    reset = 1'b1; tick();
    check("rm_state", 64'(state), 64'd0);
    check("rm_perr", 64'(protocol_err), 64'd0);
    check("rm_txn", 64'(txn_count), 64'd0);
    check("rm_min", 64'(lat_min), 64'hFFFF_FFFF);
    reset = 1'b0; tick();
    check("rm_no_done", 64'(txn_count), 64'd0);

    // Protocol error: ready while IDLE without start
    ap_ready = 1'b1; tick();
    check("pe_ready", 64'(protocol_err), 64'd1);
    ap_ready = 1'b0; tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
